// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) then opcode-dependent execute steps (T3-T6),
// with a terminal HALT state left only through the synchronous active-low clear.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic [15:0] R_rd,
    output logic [15:0] R_wrt,
    output logic        PC_out,
    output logic        MDR_out,
    output logic        Zhi_out,
    output logic        Zlo_out,
    output logic        HI_out,
    output logic        LO_out,
    output logic        C_out,
    output logic        MAR_rd,
    output logic        PC_rd,
    output logic        MDR_rd,
    output logic        IR_rd,
    output logic        Y_rd,
    output logic        Zlo_rd,
    output logic        Zhi_rd,
    output logic        HI_rd,
    output logic        LO_rd,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  op_sel,
    output logic        Run
);

    typedef enum logic [3:0] {
        StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsNop, ClsAlu, ClsImm, ClsMulDiv, ClsUnary, ClsHalt
    } cls_e;

    state_e      state_q, state_d;
    logic [16:0] fields_q;
    logic [16:0] fields;
    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    cls_e        cls;
    logic [4:0]  imm_op;
    logic        unused_ir_bits;

    function automatic logic [15:0] sel16(input logic [3:0] n);
        sel16 = 16'd1 << n;
    endfunction

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= StRst;
            fields_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StT3) begin
                fields_q <= IR[31:15];
            end
        end
    end

    // T3 decodes straight from IR; later steps use the copy captured at the end of T3.
    assign fields         = (state_q == StT3) ? IR[31:15] : fields_q;
    assign opcode         = fields[16:12];
    assign ra             = fields[11:8];
    assign rb             = fields[7:4];
    assign rc             = fields[3:0];
    assign unused_ir_bits = ^IR[14:0];

    always_comb begin
        cls    = ClsNop;
        imm_op = 5'b00000;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: cls = ClsAlu;
            5'b01100: begin cls = ClsImm; imm_op = 5'b00011; end
            5'b01101: begin cls = ClsImm; imm_op = 5'b00101; end
            5'b01110: begin cls = ClsImm; imm_op = 5'b00110; end
            5'b01111, 5'b10000: cls = ClsMulDiv;
            5'b10001, 5'b10010: cls = ClsUnary;
            5'b11011: cls = ClsHalt;
            default:  cls = ClsNop;
        endcase
    end

    always_comb begin
        R_rd    = '0;
        R_wrt   = '0;
        PC_out  = 1'b0;
        MDR_out = 1'b0;
        Zhi_out = 1'b0;
        Zlo_out = 1'b0;
        HI_out  = 1'b0;
        LO_out  = 1'b0;
        C_out   = 1'b0;
        MAR_rd  = 1'b0;
        PC_rd   = 1'b0;
        MDR_rd  = 1'b0;
        IR_rd   = 1'b0;
        Y_rd    = 1'b0;
        Zlo_rd  = 1'b0;
        Zhi_rd  = 1'b0;
        HI_rd   = 1'b0;
        LO_rd   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        op_sel  = 5'b00000;
        Run     = 1'b1;
        state_d = state_q;

        unique case (state_q)
            StRst: state_d = StT0;
            StT0: begin
                PC_out  = 1'b1;
                MAR_rd  = 1'b1;
                IncPC   = 1'b1;
                state_d = StT1;
            end
            StT1: begin
                Read    = 1'b1;
                MDR_rd  = 1'b1;
                state_d = StT2;
            end
            StT2: begin
                MDR_out = 1'b1;
                IR_rd   = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                unique case (cls)
                    ClsAlu, ClsImm: begin
                        R_wrt   = sel16(rb);
                        Y_rd    = 1'b1;
                        state_d = StT4;
                    end
                    ClsMulDiv: begin
                        R_wrt   = sel16(ra);
                        Y_rd    = 1'b1;
                        state_d = StT4;
                    end
                    ClsUnary: begin
                        R_wrt   = sel16(rb);
                        op_sel  = opcode;
                        Zlo_rd  = 1'b1;
                        state_d = StT4;
                    end
                    ClsHalt: state_d = StHalt;
                    default: state_d = Stop ? StHalt : StT0;
                endcase
            end
            StT4: begin
                unique case (cls)
                    ClsAlu: begin
                        R_wrt   = sel16(rc);
                        op_sel  = opcode;
                        Zlo_rd  = 1'b1;
                        state_d = StT5;
                    end
                    ClsImm: begin
                        C_out   = 1'b1;
                        op_sel  = imm_op;
                        Zlo_rd  = 1'b1;
                        state_d = StT5;
                    end
                    ClsMulDiv: begin
                        R_wrt   = sel16(rb);
                        op_sel  = opcode;
                        Zlo_rd  = 1'b1;
                        Zhi_rd  = 1'b1;
                        state_d = StT5;
                    end
                    ClsUnary: begin
                        Zlo_out = 1'b1;
                        R_rd    = sel16(ra);
                        state_d = Stop ? StHalt : StT0;
                    end
                    default: state_d = StT0;
                endcase
            end
            StT5: begin
                unique case (cls)
                    ClsAlu, ClsImm: begin
                        Zlo_out = 1'b1;
                        R_rd    = sel16(ra);
                        state_d = Stop ? StHalt : StT0;
                    end
                    ClsMulDiv: begin
                        Zlo_out = 1'b1;
                        LO_rd   = 1'b1;
                        state_d = StT6;
                    end
                    default: state_d = StT0;
                endcase
            end
            StT6: begin
                Zhi_out = 1'b1;
                HI_rd   = 1'b1;
                state_d = Stop ? StHalt : StT0;
            end
            StHalt: Run = 1'b0;
            default: state_d = StRst;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level step model checked every cycle,
// plus hand-computed literal expectations for the directed instruction vectors.
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] r_rd;
        logic [15:0] r_wrt;
        logic        pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, c_out;
        logic        mar_rd, pc_rd, mdr_rd, ir_rd, y_rd, zlo_rd, zhi_rd, hi_rd, lo_rd;
        logic        inc_pc, read;
        logic [4:0]  op_sel;
        logic        run;
    } ctl_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR;
    logic        Stop;
    logic [15:0] R_rd, R_wrt;
    logic        PC_out, MDR_out, Zhi_out, Zlo_out, HI_out, LO_out, C_out;
    logic        MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd;
    logic        IncPC, Read, Run;
    logic [4:0]  op_sel;
    ctl_t        act;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    int mmode    = 0;  // 0 reset, 1 sequencing, 2 halted
    int mstep    = 0;  // cycle index within the current instruction, 0 = T0

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR(IR), .Stop(Stop),
        .R_rd(R_rd), .R_wrt(R_wrt),
        .PC_out(PC_out), .MDR_out(MDR_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
        .HI_out(HI_out), .LO_out(LO_out), .C_out(C_out),
        .MAR_rd(MAR_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd),
        .Zlo_rd(Zlo_rd), .Zhi_rd(Zhi_rd), .HI_rd(HI_rd), .LO_rd(LO_rd),
        .IncPC(IncPC), .Read(Read), .op_sel(op_sel), .Run(Run)
    );

    assign act = {R_rd, R_wrt, PC_out, MDR_out, Zhi_out, Zlo_out, HI_out, LO_out, C_out,
                  MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd,
                  IncPC, Read, op_sel, Run};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, a, e);
    endtask

    // Instruction length in cycles, T0 through the final execute step.
    function automatic int ir_len(input logic [31:0] ir);
        int op;
        op = int'(ir[31:27]);
        if (op >= 3 && op <= 14) return 6;
        if (op == 15 || op == 16) return 7;
        if (op == 17 || op == 18) return 5;
        return 4;
    endfunction

    function automatic ctl_t model_out(input int mode, input int step, input logic [31:0] ir);
        ctl_t       v;
        int         op, k;
        logic [4:0] imm_alu [3];
        logic [3:0] ra, rb, rc;
        imm_alu = '{5'b00011, 5'b00101, 5'b00110};
        op = int'(ir[31:27]);
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];
        v  = '0;
        if (mode == 2) return v;
        v.run = 1'b1;
        if (mode == 0) return v;
        k = step - 3;
        if (step == 0) begin
            v.pc_out = 1'b1; v.mar_rd = 1'b1; v.inc_pc = 1'b1;
        end else if (step == 1) begin
            v.read = 1'b1; v.mdr_rd = 1'b1;
        end else if (step == 2) begin
            v.mdr_out = 1'b1; v.ir_rd = 1'b1;
        end else if (op >= 3 && op <= 14) begin
            if (k == 0) begin
                v.r_wrt = 16'd1 << rb; v.y_rd = 1'b1;
            end else if (k == 1) begin
                if (op >= 12) begin
                    v.c_out = 1'b1; v.op_sel = imm_alu[op - 12];
                end else begin
                    v.r_wrt = 16'd1 << rc; v.op_sel = 5'(op);
                end
                v.zlo_rd = 1'b1;
            end else begin
                v.zlo_out = 1'b1; v.r_rd = 16'd1 << ra;
            end
        end else if (op == 15 || op == 16) begin
            if (k == 0) begin
                v.r_wrt = 16'd1 << ra; v.y_rd = 1'b1;
            end else if (k == 1) begin
                v.r_wrt = 16'd1 << rb; v.op_sel = 5'(op); v.zlo_rd = 1'b1; v.zhi_rd = 1'b1;
            end else if (k == 2) begin
                v.zlo_out = 1'b1; v.lo_rd = 1'b1;
            end else begin
                v.zhi_out = 1'b1; v.hi_rd = 1'b1;
            end
        end else if (op == 17 || op == 18) begin
            if (k == 0) begin
                v.r_wrt = 16'd1 << rb; v.op_sel = 5'(op); v.zlo_rd = 1'b1;
            end else begin
                v.zlo_out = 1'b1; v.r_rd = 16'd1 << ra;
            end
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (!clr) begin
            mmode <= 0;
            mstep <= 0;
        end else if (mmode == 0) begin
            mmode <= 1;
            mstep <= 0;
        end else if (mmode == 1) begin
            if (mstep == ir_len(IR) - 1) begin
                if (IR[31:27] == 5'b11011 || Stop) mmode <= 2;
                else mstep <= 0;
            end else begin
                mstep <= mstep + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle", 64'(act), 64'(model_out(mmode, mstep, IR)));
            a_one_src: assert ($countones({PC_out, MDR_out, Zhi_out, Zlo_out, HI_out,
                                           LO_out, C_out}) + $countones(R_wrt) <= 1)
                else $error("FAIL bus_src: more than one bus source, R_wrt=%h", R_wrt);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Called while in T0; ends in the T0 of the following instruction.
    task automatic run_instr(input logic [31:0] ir, input int len);
        IR = ir;
        repeat (len) step();
        check("instr_len", 64'(PC_out), 64'd1);
    endtask

    initial begin
        clr  = 1'b0;
        Stop = 1'b0;
        IR   = 32'h0;
        step();
        step();
        chk_en = 1'b1;
        check("rst_state", 64'(act), 64'd1);

        // NEG R5,R0
        IR  = 32'h8A800000;
        clr = 1'b1;
        step(); check("neg_t0", 64'({PC_out, MAR_rd, IncPC}), 64'd7);
        step(); check("neg_t1", 64'({Read, MDR_rd}), 64'd3);
        step(); check("neg_t2", 64'({MDR_out, IR_rd}), 64'd3);
        step(); check("neg_t3_wrt", 64'(R_wrt), 64'h0001);
        check("neg_t3_op", 64'({op_sel, Zlo_rd}), 64'({5'b10001, 1'b1}));
        step(); check("neg_t4", 64'({Zlo_out, R_rd}), 64'({1'b1, 16'h0020}));
        step(); check("neg_len5", 64'(PC_out), 64'd1);

        // AND R4,R3,R7
        IR = 32'h2A1B8000;
        repeat (3) step();
        check("and_t3", 64'({R_wrt, Y_rd}), 64'({16'h0008, 1'b1}));
        step(); check("and_t4", 64'({R_wrt, op_sel}), 64'({16'h0080, 5'b00101}));
        step(); check("and_t5", 64'(R_rd), 64'h0010);
        step(); check("and_len6", 64'(PC_out), 64'd1);

        // ADDI R2,R1,-5
        IR = 32'h610FFFFB;
        repeat (3) step();
        check("addi_t3", 64'(R_wrt), 64'h0002);
        step(); check("addi_t4", 64'({C_out, R_wrt, op_sel}), 64'({1'b1, 16'h0, 5'b00011}));
        step(); check("addi_t5", 64'(R_rd), 64'h0004);
        step();

        // MUL R3,R1
        IR = 32'h79880000;
        repeat (3) step();
        check("mul_t3", 64'({R_wrt, Y_rd}), 64'({16'h0008, 1'b1}));
        step();
        check("mul_t4", 64'({Zlo_rd, Zhi_rd, R_wrt, op_sel}),
              64'({1'b1, 1'b1, 16'h0002, 5'b01111}));
        step(); check("mul_t5", 64'({Zlo_out, LO_rd}), 64'd3);
        step(); check("mul_t6", 64'({Zhi_out, HI_rd}), 64'd3);
        step(); check("mul_len7", 64'(PC_out), 64'd1);

        // Clear during T4 of an AND abandons it
        IR = 32'h2A1B8000;
        repeat (4) step();
        clr = 1'b0;
        step(); check("mid_rst", 64'(act), 64'd1);
        clr = 1'b1;
        step(); check("rst_to_t0", 64'(PC_out), 64'd1);

        // ADD R0,R15,R15 with Stop held throughout: only the final cycle honours it
        IR   = 32'h187F8000;
        Stop = 1'b1;
        repeat (3) step();
        check("add_t3", 64'(R_wrt), 64'h8000);
        step(); check("add_t4", 64'({R_wrt, op_sel}), 64'({16'h8000, 5'b00011}));
        step(); check("add_t5_r0", 64'(R_rd), 64'h0001);
        step(); check("stop_halt", 64'(act), 64'd0);
        Stop = 1'b0;
        repeat (10) step();
        check("stop_halt_hold", 64'(act), 64'd0);

        // HALT opcode
        clr = 1'b0;
        step(); check("halt_rst", 64'(act), 64'd1);
        clr = 1'b1;
        IR  = 32'hD8000000;
        repeat (4) step();
        check("halt_t3", 64'(act), 64'd1);
        step(); check("halt_enter", 64'(Run), 64'd0);
        repeat (10) step();
        check("halt_hold", 64'(act), 64'd0);
        clr = 1'b0;
        step(); check("halt_exit_rst", 64'(act), 64'd1);
        clr = 1'b1;
        step(); check("halt_exit_t0", 64'(PC_out), 64'd1);

        // Remaining opcode classes and unlisted opcodes, checked by the model
        run_instr(32'h97B80000, 5);  // NOT R15,R7
        run_instr(32'h83480000, 7);  // DIV R6,R9
        run_instr(32'h70000000, 6);  // ORI
        run_instr(32'h38000000, 6);  // ROR
        run_instr(32'h50000000, 6);  // SHRA
        run_instr(32'h00000000, 4);  // unlisted 00000
        run_instr(32'hF8000000, 4);  // unlisted 11111
        run_instr(32'hD0000000, 4);  // NOP

        // Stop in the final cycle of a NOP
        IR = 32'hD0000000;
        repeat (3) step();
        Stop = 1'b1;
        step(); check("nop_stop_halt", 64'(act), 64'd0);
        Stop = 1'b0;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
